// File: rtl/gravity_pkg.sv
// Shared types and default constants for gravity control.
// Used by gravity_ctrl and drop_period.
package gravity_pkg;

  localparam int DEF_BASE_TICKS = 8;
  localparam int DEF_MAX_LEVEL  = 7;
  localparam int DEF_LOCK_DELAY = 2;
  localparam int DEF_CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DROP_REQ  = 2'd1,
    LOCK_WAIT = 2'd2,
    LOCK_REQ  = 2'd3
  } state_t;

endpackage

// File: rtl/gravity_ctrl_drop_period.sv
// Level/soft_drop to ticks-per-drop mapping.
// Purely combinational; also usable by the level display.
module drop_period
  import gravity_pkg::*;
#(
  parameter int BASE_TICKS = DEF_BASE_TICKS,
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic [3:0]       level,
  input  logic             soft_drop,
  output logic [CNT_W-1:0] period
);

  localparam int W = CNT_W + 1;

  logic [3:0] lvl;
  logic [W-1:0] base;
  logic [W-1:0] lvl_w;
  logic [W-1:0] diff;

  // Clamp level, subtract from base, floor at one tick.
  always_comb begin
    lvl   = (level > 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level;
    base  = W'(BASE_TICKS);
    lvl_w = W'(lvl);
    diff  = (base > lvl_w) ? (base - lvl_w) : '0;
    if (soft_drop || diff == '0)
      period = CNT_W'(1);
    else
      period = diff[CNT_W-1:0];
  end

endmodule

// File: rtl/gravity_ctrl.sv
// Gravity controller: divides game ticks into drop requests,
// runs lock delay on blocked drops, then requests a lock.
module gravity_ctrl
  import gravity_pkg::*;
#(
  parameter int BASE_TICKS = DEF_BASE_TICKS,
  parameter int MAX_LEVEL  = DEF_MAX_LEVEL,
  parameter int LOCK_DELAY = DEF_LOCK_DELAY,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pause,
  input  logic       game_tick,
  input  logic       soft_drop,
  input  logic [3:0] level,
  output logic       drop_req,
  input  logic       drop_ack,
  input  logic       drop_ok,
  output logic       lock_req,
  input  logic       lock_ack,
  output logic       overrun,
  output logic [7:0] drops
);

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] lock_nxt;
  logic [CNT_W-1:0] period;
  logic [CNT_W:0]   div_inc;
  logic [CNT_W:0]   lock_inc;
  logic [7:0]       drops_nxt;
  logic             overrun_nxt;
  logic             tick_v;

  drop_period #(
    .BASE_TICKS (BASE_TICKS),
    .MAX_LEVEL  (MAX_LEVEL),
    .CNT_W      (CNT_W)
  ) u_period (
    .level     (level),
    .soft_drop (soft_drop),
    .period    (period)
  );

  assign tick_v   = game_tick & ~pause;
  assign div_inc  = {1'b0, div_cnt} + (CNT_W+1)'(1);
  assign lock_inc = {1'b0, lock_cnt} + (CNT_W+1)'(1);

  // Next-state, counter and sticky-flag logic.
  always_comb begin
    state_nxt   = state;
    div_nxt     = div_cnt;
    lock_nxt    = lock_cnt;
    drops_nxt   = drops;
    overrun_nxt = overrun;
    unique case (state)
      IDLE: begin
        if (tick_v) begin
          if (div_inc >= {1'b0, period}) begin
            div_nxt   = '0;
            state_nxt = DROP_REQ;
          end else begin
            div_nxt = div_inc[CNT_W-1:0];
          end
        end
      end
      DROP_REQ: begin
        if (tick_v)
          overrun_nxt = 1'b1;
        if (drop_ack) begin
          if (drop_ok) begin
            drops_nxt = drops + 8'd1;
            state_nxt = IDLE;
          end else begin
            lock_nxt  = '0;
            state_nxt = LOCK_WAIT;
          end
        end
      end
      LOCK_WAIT: begin
        if (tick_v) begin
          lock_nxt = lock_inc[CNT_W-1:0];
          if (lock_inc == (CNT_W+1)'(LOCK_DELAY))
            state_nxt = LOCK_REQ;
        end
      end
      LOCK_REQ: begin
        if (tick_v)
          overrun_nxt = 1'b1;
        if (lock_ack) begin
          div_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      lock_cnt <= '0;
      drops    <= '0;
      overrun  <= 1'b0;
      drop_req <= 1'b0;
      lock_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_nxt;
      lock_cnt <= lock_nxt;
      drops    <= drops_nxt;
      overrun  <= overrun_nxt;
      drop_req <= (state_nxt == DROP_REQ);
      lock_req <= (state_nxt == LOCK_REQ);
    end
  end

endmodule
